// File: rtl/cd_spi_csr_bridge.sv
// SPI mode-0 target that turns a command byte plus a data burst into CDBUS CSR
// read/write strobes; read results are shifted back out on MISO.
module cd_spi_csr_bridge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ADDR_W      = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              ss_n,
   output logic              miso,
   output logic              miso_oe,
   output logic              chip_select,
   output logic [ADDR_W-1:0] csr_address,
   output logic              csr_read,
   input  logic [7:0]        csr_readdata,
   output logic              csr_write,
   output logic [7:0]        csr_writedata
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      WR,
      RD
   } state_t;

   state_t              state, state_nxt;
   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
   logic                sclk_prev;
   logic                sclk_s, mosi_s, ss_s;
   logic                sclk_rise, sclk_fall;

   logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
   logic [BYTE_W-1:0]   rx_shift, rx_nxt, rx_shifted;
   logic [BYTE_W-1:0]   tx_shift, tx_nxt;
   logic                cs_nxt, rd_nxt, wr_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [BYTE_W-1:0]   wdata_nxt;
   logic                byte_done;

   // ss synchroniser resets to "deselected" so reset release never opens a frame
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_sync_q   <= '1;
         sclk_prev   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
         sclk_prev   <= sclk_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;

   assign rx_shifted = {rx_shift[BYTE_W-2:0], mosi_s};
   assign byte_done  = sclk_rise && (bit_cnt == CNT_W'(7));

   assign miso    = tx_shift[BYTE_W-1];
   assign miso_oe = chip_select;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         chip_select   <= 1'b0;
         csr_address   <= '0;
         csr_read      <= 1'b0;
         csr_write     <= 1'b0;
         csr_writedata <= '0;
      end else begin
         state         <= state_nxt;
         bit_cnt       <= bit_cnt_nxt;
         rx_shift      <= rx_nxt;
         tx_shift      <= tx_nxt;
         chip_select   <= cs_nxt;
         csr_address   <= addr_nxt;
         csr_read      <= rd_nxt;
         csr_write     <= wr_nxt;
         csr_writedata <= wdata_nxt;
      end
   end

   // Next-state and output logic; deselect outranks any same-cycle sclk edge
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      rx_nxt      = rx_shift;
      tx_nxt      = tx_shift;
      cs_nxt      = chip_select;
      addr_nxt    = csr_address;
      rd_nxt      = 1'b0;
      wr_nxt      = 1'b0;
      wdata_nxt   = csr_writedata;

      case (state)
         IDLE: begin
            tx_nxt      = '0;
            bit_cnt_nxt = '0;
            if (!ss_s) begin
               state_nxt = CMD;
               cs_nxt    = 1'b1;
            end
         end
         default: begin
            if (ss_s) begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
               cs_nxt      = 1'b0;
            end else begin
               if (sclk_rise) begin
                  rx_nxt      = rx_shifted;
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
               end
               case (state)
                  CMD: begin
                     if (byte_done) begin
                        addr_nxt = rx_shifted[ADDR_W-1:0];
                        if (rx_shifted[BYTE_W-1]) begin
                           state_nxt = WR;
                        end else begin
                           state_nxt = RD;
                           rd_nxt    = 1'b1;
                        end
                     end
                  end
                  WR: begin
                     if (byte_done) begin
                        wdata_nxt = rx_shifted;
                        wr_nxt    = 1'b1;
                     end
                  end
                  RD: begin
                     // The fall right after a byte boundary keeps the fresh MSB on miso
                     if (csr_read) begin
                        tx_nxt = csr_readdata;
                     end else if (sclk_fall && (bit_cnt != '0)) begin
                        tx_nxt = {tx_shift[BYTE_W-2:0], 1'b0};
                     end
                     if (byte_done) begin
                        rd_nxt = 1'b1;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      endcase
   end

endmodule

// File: tb/tb_cd_spi_csr_bridge.sv
// Directed bench for cd_spi_csr_bridge: bit-banged SPI master, CSR read model,
// and a write scoreboard checked as strobes appear.
module tb_cd_spi_csr_bridge;

   localparam int unsigned ADDR_W = 5;
   localparam int          HALF   = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              sclk = 1'b0;
   logic              mosi = 1'b0;
   logic              ss_n = 1'b1;
   logic              miso, miso_oe, chip_select;
   logic [ADDR_W-1:0] csr_address;
   logic              csr_read, csr_write;
   logic [7:0]        csr_readdata, csr_writedata;

   cd_spi_csr_bridge #(.SYNC_STAGES(2), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sclk         (sclk),
      .mosi         (mosi),
      .ss_n         (ss_n),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .chip_select  (chip_select),
      .csr_address  (csr_address),
      .csr_read     (csr_read),
      .csr_readdata (csr_readdata),
      .csr_write    (csr_write),
      .csr_writedata(csr_writedata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
   } wr_t;

   wr_t               wq[$];
   wr_t               mon_e;
   int unsigned       total = 0;
   int unsigned       passed = 0;
   int unsigned       failed = 0;
   int unsigned       wr_cnt = 0;
   int unsigned       rd_cnt = 0;
   logic [7:0]        rd_idx = 8'h00;
   logic [ADDR_W-1:0] exp_addr = '0;
   logic              addr_chk_en = 1'b0;
   logic [7:0]        rx;

   // CSR model: register 0 reads 0x0E, others stream A0, A1, ... per frame
   assign csr_readdata = (csr_address == '0) ? 8'h0E : 8'(8'hA0 + rd_idx);

   always @(posedge clk) begin
      if (!chip_select)  rd_idx <= 8'h00;
      else if (csr_read) rd_idx <= 8'(rd_idx + 8'h01);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobe monitor and write scoreboard
   always @(negedge clk) begin
      if (reset_n) begin
         if (csr_read || csr_write) chk("strobe_exclusive", 32'(csr_read & csr_write), 32'd0);
         if (csr_read) begin
            rd_cnt++;
            if (addr_chk_en) chk("rd_addr", 32'(csr_address), 32'(exp_addr));
         end
         if (csr_write) begin
            wr_cnt++;
            chk("wr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
               mon_e = wq.pop_front();
               chk("wr_addr", 32'(csr_address), 32'(mon_e.a));
               chk("wr_data", 32'(csr_writedata), 32'(mon_e.d));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
      r = '0;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = tx[i];
         tick(HALF);
         r[i] = miso;
         sclk = 1'b1;
         tick(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic frame_start();
      wr_cnt = 0;
      rd_cnt = 0;
      ss_n   = 1'b0;
      tick(8);
      chk("cs_in_frame", 32'(chip_select), 32'd1);
      chk("oe_in_frame", 32'(miso_oe), 32'd1);
   endtask

   task automatic frame_end();
      tick(HALF);
      ss_n = 1'b1;
      tick(8);
      chk("cs_after_frame", 32'(chip_select), 32'd0);
      chk("oe_after_frame", 32'(miso_oe), 32'd0);
      chk("wq_drained", 32'(wq.size()), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_miso"}, 32'(miso), 32'd0);
      chk({tag, "_oe"}, 32'(miso_oe), 32'd0);
      chk({tag, "_cs"}, 32'(chip_select), 32'd0);
      chk({tag, "_addr"}, 32'(csr_address), 32'd0);
      chk({tag, "_rd"}, 32'(csr_read), 32'd0);
      chk({tag, "_wr"}, 32'(csr_write), 32'd0);
      chk({tag, "_wdata"}, 32'(csr_writedata), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      tick(3);
      chk_reset_outputs("por");
      reset_n = 1'b1;
      tick(4);

      // Single write
      wq.push_back('{a: 5'h02, d: 8'h5A});
      frame_start();
      spi_bits(8'h82, 8, rx);
      chk("wr1_cmd_miso", 32'(rx), 32'h00);
      spi_bits(8'h5A, 8, rx);
      frame_end();
      chk("wr1_count", wr_cnt, 32'd1);
      chk("wr1_reads", rd_cnt, 32'd0);
      chk("wr1_addr_held", 32'(csr_address), 32'h02);

      // Burst write
      wq.push_back('{a: 5'h15, d: 8'h11});
      wq.push_back('{a: 5'h15, d: 8'h22});
      wq.push_back('{a: 5'h15, d: 8'h33});
      frame_start();
      spi_bits(8'h95, 8, rx);
      spi_bits(8'h11, 8, rx);
      spi_bits(8'h22, 8, rx);
      spi_bits(8'h33, 8, rx);
      frame_end();
      chk("bw_count", wr_cnt, 32'd3);
      chk("bw_reads", rd_cnt, 32'd0);

      // Single read from register 0
      addr_chk_en = 1'b1;
      exp_addr    = 5'h00;
      frame_start();
      spi_bits(8'h00, 8, rx);
      chk("rd1_cmd_miso", 32'(rx), 32'h00);
      spi_bits(8'h00, 8, rx);
      chk("rd1_miso", 32'(rx), 32'h0E);
      frame_end();
      chk("rd1_reads", rd_cnt, 32'd2);
      chk("rd1_writes", wr_cnt, 32'd0);

      // Burst read, address held
      exp_addr = 5'h14;
      frame_start();
      spi_bits(8'h14, 8, rx);
      spi_bits(8'hFF, 8, rx);
      chk("br_byte0", 32'(rx), 32'hA0);
      spi_bits(8'h00, 8, rx);
      chk("br_byte1", 32'(rx), 32'hA1);
      spi_bits(8'h5A, 8, rx);
      chk("br_byte2", 32'(rx), 32'hA2);
      chk("br_addr", 32'(csr_address), 32'h14);
      frame_end();
      chk("br_reads", rd_cnt, 32'd4);
      chk("br_writes", wr_cnt, 32'd0);
      addr_chk_en = 1'b0;

      // Abort mid-byte, then a clean write
      frame_start();
      spi_bits(8'h82, 8, rx);
      spi_bits(8'hF0, 4, rx);
      frame_end();
      chk("abort_writes", wr_cnt, 32'd0);
      chk("abort_addr", 32'(csr_address), 32'h02);
      wq.push_back('{a: 5'h02, d: 8'h33});
      frame_start();
      spi_bits(8'h82, 8, rx);
      spi_bits(8'h33, 8, rx);
      frame_end();
      chk("abort_next_writes", wr_cnt, 32'd1);

      // Reset in the middle of a read byte
      addr_chk_en = 1'b1;
      exp_addr    = 5'h14;
      frame_start();
      spi_bits(8'h14, 8, rx);
      spi_bits(8'h00, 3, rx);
      ss_n    = 1'b1;
      reset_n = 1'b0;
      tick(2);
      chk_reset_outputs("midrst");
      reset_n = 1'b1;
      tick(8);
      exp_addr = 5'h00;
      frame_start();
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 8, rx);
      chk("rst_rd_miso", 32'(rx), 32'h0E);
      frame_end();
      chk("rst_rd_reads", rd_cnt, 32'd2);
      chk("rst_rd_writes", wr_cnt, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
